// File: rtl/freq_calc_module.sv
// Frequency calculator: F = N * CLK_HZ / M via constant multiply and a 64-step restoring divider.
// Optional 8-digit BCD conversion is compiled in when FREQ_BCD_EN is defined.
module freq_calc_module #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic [31:0] M,
    input  logic [31:0] N,
    input  logic        gate_out,
    output logic [31:0] freq,
    output logic        freq_valid,
    output logic        busy,
    output logic        err_div0,
    output logic        overrun,
    output logic [31:0] bcd
);

`ifdef FREQ_BCD_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_BCD  = 3'd3,
        S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;

    logic        r_gate_d;
    logic [31:0] r_m;
    logic [31:0] r_n;
    logic [63:0] r_dq;
    logic [31:0] r_rem;
    logic [5:0]  r_cnt;
    logic [31:0] r_freq;
    logic        r_freq_valid;
    logic        r_busy;
    logic        r_err_div0;
    logic        r_overrun;

    logic        w_capture;
    logic [63:0] w_product;
    logic [32:0] w_rem_shift;
    logic        w_ge;
    logic [31:0] w_rem_diff;
    logic [31:0] w_rem_next;
    logic [63:0] w_quot_final;
    logic        w_sat;
    logic [31:0] w_div_res;

    assign w_capture = r_gate_d & ~gate_out;
    assign w_product = {32'd0, r_n} * 64'(CLK_HZ);

    // r_dq doubles as dividend (shifting out at the top) and quotient (shifting in at the bottom)
    assign w_rem_shift  = {r_rem, r_dq[63]};
    assign w_ge         = (w_rem_shift >= {1'b0, r_m});
    assign w_rem_diff   = w_rem_shift[31:0] - r_m;
    assign w_rem_next   = w_ge ? w_rem_diff : w_rem_shift[31:0];
    assign w_quot_final = {r_dq[62:0], w_ge};
    assign w_sat        = |w_quot_final[63:32];
    assign w_div_res    = w_sat ? 32'hFFFF_FFFF : w_quot_final[31:0];

`ifdef FREQ_BCD_EN
    logic [31:0] r_result;
    logic [31:0] r_bin;
    logic [31:0] r_bcd_sh;
    logic        r_bcd_sat;
    logic [31:0] r_bcd;
    logic [31:0] w_bcd_adj;
    logic [31:0] w_bcd_shift;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dabble
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd_sh[gi*4 +: 4] >= 4'd5) ?
                                          (r_bcd_sh[gi*4 +: 4] + 4'd3) :
                                          r_bcd_sh[gi*4 +: 4];
        end
    endgenerate

    assign w_bcd_shift = {w_bcd_adj[30:0], r_bin[31]};
    assign bcd         = r_bcd;
`else
    assign bcd         = 32'd0;
`endif

    assign freq       = r_freq;
    assign freq_valid = r_freq_valid;
    assign busy       = r_busy;
    assign err_div0   = r_err_div0;
    assign overrun    = r_overrun;

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) w_state_next = S_MUL;
            end
            S_MUL: begin
                if (r_m == 32'd0) begin
`ifdef FREQ_BCD_EN
                    w_state_next = S_BCD;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_state_next = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == 6'd63) begin
`ifdef FREQ_BCD_EN
                    w_state_next = S_BCD;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef FREQ_BCD_EN
            S_BCD: begin
                if (r_cnt == 6'd31) w_state_next = S_DONE;
            end
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            r_gate_d     <= 1'b0;
            r_m          <= 32'd0;
            r_n          <= 32'd0;
            r_dq         <= 64'd0;
            r_rem        <= 32'd0;
            r_cnt        <= 6'd0;
            r_freq       <= 32'd0;
            r_freq_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_err_div0   <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef FREQ_BCD_EN
            r_result     <= 32'd0;
            r_bin        <= 32'd0;
            r_bcd_sh     <= 32'd0;
            r_bcd_sat    <= 1'b0;
            r_bcd        <= 32'd0;
`endif
        end else begin
            r_gate_d     <= gate_out;
            r_freq_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_m       <= M;
                        r_n       <= N;
                        r_overrun <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_dq  <= w_product;
                    r_rem <= 32'd0;
                    r_cnt <= 6'd0;
                    if (r_m == 32'd0) begin
                        r_err_div0 <= 1'b1;
`ifdef FREQ_BCD_EN
                        r_result  <= 32'd0;
                        r_bin     <= 32'd0;
                        r_bcd_sh  <= 32'd0;
                        r_bcd_sat <= 1'b0;
`else
                        r_freq       <= 32'd0;
                        r_freq_valid <= 1'b1;
`endif
                    end
                end
                S_DIV: begin
                    r_dq  <= w_quot_final;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) begin
                        r_err_div0 <= 1'b0;
`ifdef FREQ_BCD_EN
                        r_cnt     <= 6'd0;
                        r_result  <= w_div_res;
                        r_bin     <= w_div_res;
                        r_bcd_sh  <= 32'd0;
                        r_bcd_sat <= (w_div_res > 32'd99_999_999);
`else
                        r_freq       <= w_div_res;
                        r_freq_valid <= 1'b1;
`endif
                    end
                end
`ifdef FREQ_BCD_EN
                S_BCD: begin
                    r_bin     <= {r_bin[30:0], 1'b0};
                    r_bcd_sh  <= w_bcd_shift;
                    r_bcd_sat <= r_bcd_sat | w_bcd_adj[31];
                    r_cnt     <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_freq       <= r_result;
                        r_bcd        <= (r_bcd_sat | w_bcd_adj[31]) ? 32'h9999_9999 : w_bcd_shift;
                        r_freq_valid <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase

            // A capture outside IDLE (including the DONE cycle) is dropped and flagged
            if (w_capture && (r_state != S_IDLE)) r_overrun <= 1'b1;
        end
    end

endmodule
